// File: rtl/serial_scan_ctrl.sv
// Round-robin front end for a shared serial_detector: clears it, streams the granted
// word LSB-first, and gathers the hit count and first match position.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; grant is issued from here
// CLEAR | one cycle with the detector held in reset, results cleared
// SHIFT | WORD_W cycles driving word bits LSB-first
// DRAIN | DET_LAT cycles of zeros while the last windows resolve
// DONE  | one-cycle result-valid pulse
module serial_scan_ctrl #(
  parameter int WORD_W  = 16,
  parameter int DET_LAT = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [1:0]                    i_req,
  input  logic [WORD_W-1:0]             i_word0,
  input  logic [WORD_W-1:0]             i_word1,
  output logic [1:0]                    o_gnt,
  output logic                          o_busy,
  output logic                          o_det_rst,
  output logic                          o_det_data,
  input  logic                          i_det_hit,
  output logic                          o_done,
  output logic                          o_done_id,
  output logic [$clog2(WORD_W+1)-1:0]   o_hit_cnt,
  output logic                          o_found,
  output logic [$clog2(WORD_W)-1:0]     o_first_pos
);

  localparam int CNT_W  = $clog2(WORD_W + 1);
  localparam int POS_W  = $clog2(WORD_W);
  localparam int TMR_W  = $clog2(WORD_W);
  localparam int SCAN_W = $clog2(WORD_W + DET_LAT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t              state;
  logic                last_id;
  logic [WORD_W-1:0]   word_sr;
  logic [TMR_W-1:0]    tmr;
  logic [SCAN_W-1:0]   scan_idx;
  logic                gnt_vld;
  logic                gnt_id;
  logic                hit_take;

  // Grant is combinational so it lands in the IDLE cycle in which the word is sampled.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state == ST_IDLE) begin
      if (i_req == 2'b11) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_id;
      end else if (i_req[0]) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (i_req[1]) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign o_gnt = {gnt_vld & gnt_id, gnt_vld & ~gnt_id};

  assign hit_take = i_det_hit &&
                    ((state == ST_SHIFT && scan_idx >= SCAN_W'(DET_LAT)) || state == ST_DRAIN);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      last_id     <= 1'b1;
      word_sr     <= '0;
      tmr         <= '0;
      scan_idx    <= '0;
      o_busy      <= 1'b0;
      o_det_rst   <= 1'b1;
      o_det_data  <= 1'b0;
      o_done      <= 1'b0;
      o_done_id   <= 1'b0;
      o_hit_cnt   <= '0;
      o_found     <= 1'b0;
      o_first_pos <= '0;
    end else begin
      o_det_rst  <= 1'b0;
      o_det_data <= 1'b0;
      o_done     <= 1'b0;

      if (hit_take) begin
        o_hit_cnt <= o_hit_cnt + CNT_W'(1);
        if (!o_found) begin
          o_found     <= 1'b1;
          o_first_pos <= POS_W'(scan_idx - SCAN_W'(DET_LAT));
        end
      end

      unique case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            state       <= ST_CLEAR;
            o_busy      <= 1'b1;
            o_det_rst   <= 1'b1;
            last_id     <= gnt_id;
            o_done_id   <= gnt_id;
            word_sr     <= gnt_id ? i_word1 : i_word0;
            o_hit_cnt   <= '0;
            o_found     <= 1'b0;
            o_first_pos <= '0;
          end
        end
        ST_CLEAR: begin
          state      <= ST_SHIFT;
          tmr        <= TMR_W'(WORD_W - 1);
          scan_idx   <= '0;
          o_det_data <= word_sr[0];
          word_sr    <= word_sr >> 1;
        end
        ST_SHIFT: begin
          scan_idx <= scan_idx + SCAN_W'(1);
          word_sr  <= word_sr >> 1;
          // The bit loaded here is shown next cycle; after the last bit the line drops to 0.
          if (tmr == '0) begin
            state <= ST_DRAIN;
            tmr   <= TMR_W'(DET_LAT - 1);
          end else begin
            tmr        <= tmr - TMR_W'(1);
            o_det_data <= word_sr[0];
          end
        end
        ST_DRAIN: begin
          scan_idx <= scan_idx + SCAN_W'(1);
          if (tmr == '0) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_scan_ctrl.sv
// Scoreboard bench for serial_scan_ctrl with a behavioural 9-bit pattern detector
// (sequence 1,1,1,0,0,0,1,0,1 in arrival order, 2-cycle latency).
module tb_serial_scan_ctrl;

  localparam int W = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [1:0]    i_req;
  logic [W-1:0]  i_word0, i_word1;
  logic [1:0]    o_gnt;
  logic          o_busy, o_det_rst, o_det_data, i_det_hit;
  logic          o_done, o_done_id, o_found;
  logic [4:0]    o_hit_cnt;
  logic [3:0]    o_first_pos;

  serial_scan_ctrl #(.WORD_W(W), .DET_LAT(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
    .i_word0(i_word0), .i_word1(i_word1), .o_gnt(o_gnt),
    .o_busy(o_busy), .o_det_rst(o_det_rst), .o_det_data(o_det_data),
    .i_det_hit(i_det_hit), .o_done(o_done), .o_done_id(o_done_id),
    .o_hit_cnt(o_hit_cnt), .o_found(o_found), .o_first_pos(o_first_pos)
  );

  always #5 i_clk = ~i_clk;

  // Detector stand-in: newest bit in det_sr[0], hit registered one cycle after the window fills.
  logic [8:0] det_sr;
  logic       det_hit_r;
  always @(posedge i_clk) begin
    if (o_det_rst) begin
      det_sr    <= '0;
      det_hit_r <= 1'b0;
    end else begin
      det_sr    <= {det_sr[7:0], o_det_data};
      det_hit_r <= (det_sr == 9'b111000101);
    end
  end
  assign i_det_hit = det_hit_r;

  typedef struct {
    logic       id;
    logic [4:0] cnt;
    logic       fnd;
    logic [3:0] pos;
  } res_t;

  typedef struct {
    int         id;
    logic [W-1:0] w;
    logic [4:0] cnt;
    logic       fnd;
    logic [3:0] pos;
  } vec_t;

  logic [1:0] gnt_q[$];
  res_t       res_q[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   g_cyc = 0;
  int   last_done_cyc = 0;
  logic [W-1:0] g_word = '0;
  logic job_on = 1'b0;
  logic mon_en = 1'b0;
  logic rst_prev = 1'b1;
  logic b2b = 1'b0;
  logic armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: grant order, detector drive, busy, and result pops on o_done.
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_gnt != 2'b00) begin
        if (gnt_q.size() == 0) chk("unexpected_gnt", 32'(o_gnt), 0);
        else chk("gnt_order", 32'(o_gnt), 32'(gnt_q.pop_front()));
        if (b2b && armed) chk("gnt_after_done", cyc, last_done_cyc + 1);
        armed  = 1'b0;
        job_on = 1'b1;
        g_cyc  = cyc;
        g_word = o_gnt[1] ? i_word1 : i_word0;
      end
      chk("det_rst", 32'(o_det_rst), 32'(rst_prev || (job_on && cyc == g_cyc + 1)));
      if (job_on && cyc >= g_cyc + 2 && cyc <= g_cyc + 1 + W)
        chk("det_data", 32'(o_det_data), 32'(g_word[cyc - g_cyc - 2]));
      else
        chk("det_data_idle", 32'(o_det_data), 0);
      chk("busy", 32'(o_busy), 32'(job_on && cyc > g_cyc));
      if (o_done) begin
        chk("done_timing", job_on ? 32'(cyc - g_cyc) : 32'hFFFF_FFFF, 32'(W + 4));
        if (res_q.size() == 0) begin
          chk("unexpected_done", 32'(o_done), 0);
        end else begin
          res_t r;
          r = res_q.pop_front();
          chk("done_id",   32'(o_done_id),   32'(r.id));
          chk("hit_cnt",   32'(o_hit_cnt),   32'(r.cnt));
          chk("found",     32'(o_found),     32'(r.fnd));
          chk("first_pos", 32'(o_first_pos), 32'(r.pos));
        end
        job_on        = 1'b0;
        last_done_cyc = cyc;
        armed         = b2b;
      end
      if (i_rst) job_on = 1'b0;
    end
    rst_prev = i_rst;
  end

  task automatic issue(input int id, input logic [W-1:0] w, input logic exp_res,
                       input logic [4:0] cnt, input logic fnd, input logic [3:0] pos);
    logic got;
    if (id == 0) i_word0 = w; else i_word1 = w;
    gnt_q.push_back(id == 0 ? 2'b01 : 2'b10);
    if (exp_res) res_q.push_back('{id[0], cnt, fnd, pos});
    i_req[id] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge i_clk);
      if (o_gnt[id]) got = 1'b1;
    end
    if (!got) chk("gnt_timeout", 0, 1);
    @(posedge i_clk);
    #1 i_req[id] = 1'b0;
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge i_clk);
      if (o_done) got = 1'b1;
    end
    if (!got) chk("done_timeout", 0, 1);
    @(posedge i_clk);
    #1;
  endtask

  vec_t vecs[5] = '{
    '{0, 16'h0000, 5'd0, 1'b0, 4'd0},
    '{1, 16'hFFFF, 5'd0, 1'b0, 4'd0},
    '{0, 16'h0A38, 5'd1, 1'b1, 4'd11},
    '{1, 16'h0147, 5'd1, 1'b1, 4'd8},
    '{0, 16'hA380, 5'd1, 1'b1, 4'd15}
  };

  initial begin
    i_rst = 1'b1; i_req = 2'b00; i_word0 = '0; i_word1 = '0;
    @(posedge i_clk);
    #1 mon_en = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    @(negedge i_clk);
    chk("rst_gnt",       32'(o_gnt), 0);
    chk("rst_busy",      32'(o_busy), 0);
    chk("rst_done",      32'(o_done), 0);
    chk("rst_done_id",   32'(o_done_id), 0);
    chk("rst_hit_cnt",   32'(o_hit_cnt), 0);
    chk("rst_found",     32'(o_found), 0);
    chk("rst_first_pos", 32'(o_first_pos), 0);
    chk("rst_det_rst",   32'(o_det_rst), 1);
    @(posedge i_clk);
    #1;

    // Held contention: last_id resets to 1, so order is 0,1,0,1, each right after o_done.
    i_word0 = 16'h0147;
    i_word1 = 16'hA380;
    for (int i = 0; i < 2; i++) begin
      gnt_q.push_back(2'b01);
      gnt_q.push_back(2'b10);
      res_q.push_back('{1'b0, 5'd1, 1'b1, 4'd8});
      res_q.push_back('{1'b1, 5'd1, 1'b1, 4'd15});
    end
    b2b   = 1'b1;
    i_req = 2'b11;
    for (int i = 0; i < 4; i++) wait_done();
    i_req = 2'b00;
    b2b   = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;

    foreach (vecs[i]) begin
      issue(vecs[i].id, vecs[i].w, 1'b1, vecs[i].cnt, vecs[i].fnd, vecs[i].pos);
      wait_done();
    end

    // Reset at SHIFT k=5: grant cycle G, issue returns in G+1, reset held during G+7.
    issue(0, 16'hA380, 1'b0, 5'd0, 1'b0, 4'd0);
    repeat (6) @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("midrst_busy",    32'(o_busy), 0);
    chk("midrst_det_rst", 32'(o_det_rst), 1);
    chk("midrst_hit_cnt", 32'(o_hit_cnt), 0);
    @(negedge i_clk);
    chk("midrst_det_rst_1cyc", 32'(o_det_rst), 0);
    repeat (30) @(negedge i_clk);
    @(posedge i_clk);
    #1;
    issue(0, 16'h0147, 1'b1, 5'd1, 1'b1, 4'd8);
    wait_done();

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("gnt_q_drained", 32'(gnt_q.size()), 0);
    chk("res_q_drained", 32'(res_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

endmodule
